// File: rtl/constantin_apply.sv
// Applies a constantinReader value (or a runtime override) to a WIDTH-bit field once the consumer has been quiet for SETTLE_CYCLES edges.
// Optional build macro CONSTANTIN_APPLY_SATURATE_EN: out-of-range values saturate instead of truncating.
module constantin_apply #(
   parameter int               WIDTH         = 8,
   parameter int               SETTLE_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [63:0]      raw_value,
   input  logic             upd_valid,
   output logic             upd_ready,
   input  logic [63:0]      upd_data,
   input  logic             quiet,
   output logic [WIDTH-1:0] value,
   output logic             applied,
   output logic             busy,
   output logic [7:0]       upd_count
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {INIT, IDLE, WAIT_QUIET, SETTLE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             applied_q, applied_d;
   logic [7:0]       count_q, count_d;

   function automatic logic [WIDTH-1:0] conv(input logic [63:0] x);
      logic [WIDTH-1:0] r;
      r = x[WIDTH-1:0];
`ifdef CONSTANTIN_APPLY_SATURATE_EN
      // Any bit above the field means the value is out of range.
      if (WIDTH < 64 && (x >> WIDTH) != 64'd0) r = '1;
`endif
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      value_d   = value_q;
      cnt_d     = cnt_q;
      applied_d = 1'b0;
      count_d   = count_q;
      case (state_q)
         INIT: begin
            pend_d  = conv(raw_value);
            state_d = WAIT_QUIET;
         end
         IDLE: begin
            if (upd_valid) begin
               pend_d  = conv(upd_data);
               state_d = WAIT_QUIET;
            end
         end
         WAIT_QUIET: begin
            if (quiet) begin
               cnt_d   = CNT_LOAD;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (!quiet) begin
               state_d = WAIT_QUIET;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               value_d   = pend_q;
               applied_d = 1'b1;
               if (count_q != 8'hFF) count_d = count_q + 8'd1;
               state_d   = IDLE;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= INIT;
         pend_q    <= '0;
         value_q   <= RESET_VALUE;
         cnt_q     <= '0;
         applied_q <= 1'b0;
         count_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         value_q   <= value_d;
         cnt_q     <= cnt_d;
         applied_q <= applied_d;
         count_q   <= count_d;
      end
   end

   assign upd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign value     = value_q;
   assign applied   = applied_q;
   assign upd_count = count_q;

endmodule
